// File: rtl/mips_alu_mc.sv
// mips_alu_mc: multi-cycle MIPS ALU with a valid/ready handshake on both sides.
// Single-cycle ops register their result at the accept edge. MUL runs an
// iterative shift-add multiply, one step per cycle, over WIDTH cycles.
module mips_alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] ALUOutHi,
    output logic             Zero,
    output logic             Overflow,
    output logic             Error
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd12;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state, state_nxt;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] mcand;     // multiplicand, constant during MUL
    logic [WIDTH-1:0] mplier;    // multiplier; shifts right, collects product low half
    logic [WIDTH-1:0] acc;       // product high half

    logic             accept;
    logic             is_mul_op;
    logic             mul_last;

    logic [WIDTH-1:0] sum, diff, res;
    logic             ovf, err;
    logic [SHW-1:0]   sh;

    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi, step_lo;

    // Accept only in IDLE, and only when the output slot is free or being drained
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul_op = (ALUCtl == OP_MUL);
    assign mul_last  = (state == MUL) && (cnt == SHW'(WIDTH - 1));

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: enter MUL on an accepted MUL, leave after the last step
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mul_op) state_nxt = MUL;
            MUL:     if (mul_last)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle result and flags from the live operands
    always_comb begin
        sum  = A + B;
        diff = A - B;
        sh   = B[SHW-1:0];
        res  = '0;
        ovf  = 1'b0;
        err  = 1'b0;
        case (ALUCtl)
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_NOR:  res = ~(A | B);
            OP_ADD: begin
                res = sum;
                ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  res = A << sh;
            OP_SRL:  res = A >> sh;
            OP_SRA:  res = $unsigned($signed(A) >>> sh);
            default: err = 1'b1;
        endcase
    end

    // One shift-add step: add multiplicand if multiplier LSB set, shift {acc,mplier} right
    always_comb begin
        step_sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        step_hi  = step_sum[WIDTH:1];
        step_lo  = {step_sum[0], mplier[WIDTH-1:1]};
    end

    // Datapath: operand capture, multiply iteration, result/flag registers, out_valid
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid <= 1'b0;
            ALUOut    <= '0;
            ALUOutHi  <= '0;
            Zero      <= 1'b1;
            Overflow  <= 1'b0;
            Error     <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
        end else begin
            if (accept) begin
                if (is_mul_op) begin
                    mcand     <= A;
                    mplier    <= B;
                    acc       <= '0;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end else begin
                    ALUOut    <= res;
                    ALUOutHi  <= '0;
                    Zero      <= (res == '0);
                    Overflow  <= ovf;
                    Error     <= err;
                    out_valid <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // out_valid is always 0 while in MUL, so this never races the drain above
            if (state == MUL) begin
                acc    <= step_hi;
                mplier <= step_lo;
                cnt    <= cnt + SHW'(1);
                if (mul_last) begin
                    ALUOut    <= step_lo;
                    ALUOutHi  <= step_hi;
                    Zero      <= (step_lo == '0);
                    Overflow  <= 1'b0;
                    Error     <= 1'b0;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_alu_mc.sv
// Directed testbench for mips_alu_mc (WIDTH=32) with hand-computed expectations.
module tb_mips_alu_mc;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUCtl;
    logic [31:0] A, B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUOut, ALUOutHi;
    logic        Zero, Overflow, Error;

    int errors = 0;
    int checks = 0;

    mips_alu_mc #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUCtl(ALUCtl), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUOut(ALUOut), .ALUOutHi(ALUOutHi),
        .Zero(Zero), .Overflow(Overflow), .Error(Error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an op before the edge, let it be sampled, then drop in_valid
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        in_valid = 1'b1; ALUCtl = c; A = a; B = b;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    // Check a single-cycle result right after its accept edge
    task automatic res_chk(input string tag, input logic [31:0] r, input logic z,
                           input logic ov, input logic er);
        chk({tag, ".vld"}, {63'd0, out_valid}, 64'd1);
        chk({tag, ".out"}, {32'd0, ALUOut}, {32'd0, r});
        chk({tag, ".hi"},  {32'd0, ALUOutHi}, 64'd0);
        chk({tag, ".z"},   {63'd0, Zero}, {63'd0, z});
        chk({tag, ".ov"},  {63'd0, Overflow}, {63'd0, ov});
        chk({tag, ".err"}, {63'd0, Error}, {63'd0, er});
    endtask

    logic [3:0]  s_ctl [8];
    logic [31:0] s_a   [8];
    logic [31:0] s_b   [8];
    logic [31:0] s_exp [8];
    logic [63:0] prod;

    initial begin
        RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALUCtl = 4'd0; A = '0; B = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.vld",  {63'd0, out_valid}, 64'd0);
        chk("rst.out",  {32'd0, ALUOut}, 64'd0);
        chk("rst.hi",   {32'd0, ALUOutHi}, 64'd0);
        chk("rst.z",    {63'd0, Zero}, 64'd1);
        chk("rst.ov",   {63'd0, Overflow}, 64'd0);
        chk("rst.err",  {63'd0, Error}, 64'd0);
        chk("rst.rdy",  {63'd0, in_ready}, 64'd1);
        @(negedge CLK); RESET = 1'b0;

        issue(4'd2, 32'd3, 32'd4);                 res_chk("add", 32'd7, 1'b0, 1'b0, 1'b0);
        issue(4'd2, 32'h7FFFFFFF, 32'd1);          res_chk("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);
        issue(4'd6, 32'hD, 32'hD);                 res_chk("sub", 32'd0, 1'b1, 1'b0, 1'b0);
        issue(4'd6, 32'h80000000, 32'd1);          res_chk("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        issue(4'd7, 32'hFFFFFFFF, 32'd1);          res_chk("slt", 32'd1, 1'b0, 1'b0, 1'b0);
        issue(4'd8, 32'hFFFFFFFF, 32'd1);          res_chk("sltu", 32'd0, 1'b1, 1'b0, 1'b0);
        issue(4'd12, 32'd2, 32'd4);                res_chk("nor", 32'hFFFFFFF9, 1'b0, 1'b0, 1'b0);
        issue(4'd5, 32'h80000000, 32'h24);         res_chk("sra", 32'hF8000000, 1'b0, 1'b0, 1'b0);
        issue(4'd4, 32'h80000000, 32'h24);         res_chk("srl", 32'h08000000, 1'b0, 1'b0, 1'b0);
        issue(4'd3, 32'h00000001, 32'hFFFFFFE1);   res_chk("sll", 32'h00000002, 1'b0, 1'b0, 1'b0);
        issue(4'd4, 32'h12345678, 32'h40);         res_chk("srl0", 32'h12345678, 1'b0, 1'b0, 1'b0);

        // MUL 0xFFFFFFFF * 2: busy for 32 cycles, result visible 32 cycles after accept
        issue(4'd9, 32'hFFFFFFFF, 32'd2);
        chk("mul.acc_vld", {63'd0, out_valid}, 64'd0);
        chk("mul.acc_rdy", {63'd0, in_ready}, 64'd0);
        for (int k = 1; k < 32; k++) begin
            @(posedge CLK); #1;
            chk("mul.busy_rdy", {63'd0, in_ready}, 64'd0);
            chk("mul.busy_vld", {63'd0, out_valid}, 64'd0);
        end
        @(posedge CLK); #1;
        chk("mul.vld", {63'd0, out_valid}, 64'd1);
        chk("mul.lo",  {32'd0, ALUOut}, 64'hFFFFFFFE);
        chk("mul.hi",  {32'd0, ALUOutHi}, 64'd1);
        chk("mul.z",   {63'd0, Zero}, 64'd0);
        chk("mul.rdy", {63'd0, in_ready}, 64'd1);

        // Second MUL with arbitrary operands, bounded wait for completion
        prod = 64'h12345678 * 64'h9ABCDEF0;
        issue(4'd9, 32'h12345678, 32'h9ABCDEF0);
        for (int k = 0; k < 40 && !out_valid; k++) begin
            @(posedge CLK); #1;
        end
        chk("mul2.vld", {63'd0, out_valid}, 64'd1);
        chk("mul2.prod", {ALUOutHi, ALUOut}, prod);

        // MUL abandoned by RESET
        issue(4'd9, 32'hFFFFFFFF, 32'd2);
        repeat (10) @(posedge CLK);
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("mulrst.vld", {63'd0, out_valid}, 64'd0);
        chk("mulrst.rdy", {63'd0, in_ready}, 64'd1);
        chk("mulrst.out", {32'd0, ALUOut}, 64'd0);
        repeat (40) @(posedge CLK);
        #1;
        chk("mulrst.late_vld", {63'd0, out_valid}, 64'd0);

        // Backpressure: result held, in_ready low, a pending op not taken
        out_ready = 1'b0;
        issue(4'd0, 32'hF0, 32'h3C);
        res_chk("hold.and", 32'h30, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        in_valid = 1'b1; ALUCtl = 4'd2; A = 32'd1; B = 32'd1;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            chk("hold.out", {32'd0, ALUOut}, 64'h30);
            chk("hold.vld", {63'd0, out_valid}, 64'd1);
            chk("hold.rdy", {63'd0, in_ready}, 64'd0);
        end
        @(negedge CLK);
        out_ready = 1'b1; ALUCtl = 4'd1; A = 32'd1; B = 32'd2;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        res_chk("drain_acc", 32'd3, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        chk("drain.vld", {63'd0, out_valid}, 64'd0);
        chk("drain.keep", {32'd0, ALUOut}, 64'd3);
        chk("drain.rdy", {63'd0, in_ready}, 64'd1);

        // Illegal opcodes, then a legal op clears Error
        issue(4'd15, 32'h55, 32'hAA);              res_chk("ill15", 32'd0, 1'b1, 1'b0, 1'b1);
        issue(4'd10, 32'hFFFF, 32'd1);             res_chk("ill10", 32'd0, 1'b1, 1'b0, 1'b1);
        issue(4'd2, 32'd5, 32'd6);                 res_chk("clr_err", 32'd11, 1'b0, 1'b0, 1'b0);

        // Streaming: 8 back-to-back ops, one result per cycle
        s_ctl[0] = 4'd2;  s_a[0] = 32'd10;         s_b[0] = 32'd20;        s_exp[0] = 32'd30;
        s_ctl[1] = 4'd6;  s_a[1] = 32'd5;          s_b[1] = 32'd7;         s_exp[1] = 32'hFFFFFFFE;
        s_ctl[2] = 4'd0;  s_a[2] = 32'hFF00FF00;   s_b[2] = 32'h0FF00FF0;  s_exp[2] = 32'h0F000F00;
        s_ctl[3] = 4'd1;  s_a[3] = 32'h00F0;       s_b[3] = 32'h0F00;      s_exp[3] = 32'h0FF0;
        s_ctl[4] = 4'd3;  s_a[4] = 32'h1;          s_b[4] = 32'd31;        s_exp[4] = 32'h80000000;
        s_ctl[5] = 4'd7;  s_a[5] = 32'd3;          s_b[5] = 32'hFFFFFFFE;  s_exp[5] = 32'd0;
        s_ctl[6] = 4'd8;  s_a[6] = 32'd3;          s_b[6] = 32'hFFFFFFFE;  s_exp[6] = 32'd1;
        s_ctl[7] = 4'd12; s_a[7] = 32'h0;          s_b[7] = 32'h0;         s_exp[7] = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) begin
            issue(s_ctl[i], s_a[i], s_b[i]);
            chk("stream.vld", {63'd0, out_valid}, 64'd1);
            chk("stream.out", {32'd0, ALUOut}, {32'd0, s_exp[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
